// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: address and sequencing controller for the 4-line BRAM delay chain
// that feeds the 5x5 conv filter. Tracks de_in/vs_in timing, drives the shared
// line-buffer address, counts rows and flags complete window columns.
// Optional feature macro: LINE_LEN_CHECK_EN (sticky line-length mismatch flag len_err).
module line_buf_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WIN    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] row_cnt,
  output logic              frame_start,
  output logic              line_end,
  output logic              win_valid,
  output logic [1:0]        state
`ifdef LINE_LEN_CHECK_EN
  ,
  output logic              len_err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ROW_FULL = ADDR_W'(WIN - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
  logic              frame_start_q, frame_start_d;
  logic              line_end_q, line_end_d;
  logic              win_valid_q, win_valid_d;
  logic              abort_q, abort_d;
  logic              de_q, vs_q;
  logic              vs_rise, de_fall;

`ifdef LINE_LEN_CHECK_EN
  logic [ADDR_W-1:0] len_q, len_d;
  logic              len_seen_q, len_seen_d;
  logic              len_err_q, len_err_d;
`endif

  // Edge detection against the previous-cycle input samples.
  assign vs_rise = vs_in & ~vs_q;
  assign de_fall = ~de_in & de_q;

  // Next-state, address, row counter and pulse generation.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    row_cnt_d     = row_cnt_q;
    frame_start_d = 1'b0;
    line_end_d    = 1'b0;
    abort_d       = abort_q;
    win_valid_d   = de_in & (state_q == STREAM) & (addr_q >= ROW_FULL);

    if (vs_rise) begin
      // New frame: restart everything; a line still in flight is aborted and
      // its trailing de_in fall is not counted as a completed line.
      state_d       = PRIME;
      addr_d        = '0;
      row_cnt_d     = '0;
      frame_start_d = 1'b1;
      abort_d       = de_in;
    end else if (state_q != IDLE) begin
      addr_d = de_in ? addr_q + ONE : '0;
      if (de_fall) begin
        abort_d = 1'b0;
        if (!abort_q) begin
          line_end_d = 1'b1;
          if (row_cnt_q != ADDR_MAX) row_cnt_d = row_cnt_q + ONE;
          if ((state_q == PRIME) && (row_cnt_d >= ROW_FULL)) state_d = STREAM;
        end
      end
    end
  end

`ifdef LINE_LEN_CHECK_EN
  // Line-length tracking: first line of a frame sets the reference length.
  always_comb begin
    len_d      = len_q;
    len_seen_d = len_seen_q;
    len_err_d  = len_err_q;
    if (vs_rise) begin
      len_seen_d = 1'b0;
      len_err_d  = 1'b0;
    end else if (state_q != IDLE) begin
      if (de_in && (addr_q == ADDR_MAX)) len_err_d = 1'b1;
      if (de_fall && !abort_q) begin
        len_d      = addr_q;
        len_seen_d = 1'b1;
        if (len_seen_q && (addr_q != len_q)) len_err_d = 1'b1;
      end
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      row_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      win_valid_q   <= 1'b0;
      abort_q       <= 1'b0;
      de_q          <= 1'b0;
      vs_q          <= 1'b0;
`ifdef LINE_LEN_CHECK_EN
      len_q         <= '0;
      len_seen_q    <= 1'b0;
      len_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      row_cnt_q     <= row_cnt_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      win_valid_q   <= win_valid_d;
      abort_q       <= abort_d;
      de_q          <= de_in;
      vs_q          <= vs_in;
`ifdef LINE_LEN_CHECK_EN
      len_q         <= len_d;
      len_seen_q    <= len_seen_d;
      len_err_q     <= len_err_d;
`endif
    end
  end

  assign addr        = addr_q;
  assign row_cnt     = row_cnt_q;
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;
  assign win_valid   = win_valid_q;
  assign state       = state_q;
`ifdef LINE_LEN_CHECK_EN
  assign len_err     = len_err_q;
`endif

endmodule
